// File: rtl/mux_scan.sv
// Registered N-channel, W-bit multiplexer with a direct-select mode and an
// automatic channel-scan mode (programmable dwell, wrap pulse once per sweep).
module mux_scan #(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int DW = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   s,
  input  logic [N*W-1:0]  a,
  input  logic [DW-1:0]   dwell,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   ch,
  output logic            y_valid,
  output logic            wrap
);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  localparam logic [SW:0]   NumCh  = (SW+1)'(N);
  localparam logic [SW-1:0] LastCh = SW'(N-1);

  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q;
  logic [DW-1:0] cnt_q;
  logic [W-1:0]  y_q;
  logic [SW-1:0] ch_q;
  logic          valid_q;
  logic          wrap_q;
  logic          prevScan;
  logic          sInRange;
  logic [W-1:0]  chan [N];

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan[k] = a[k*W +: W];
  end

  // A select code beyond the last channel can only occur when N is not a power of 2.
  assign sInRange = ({1'b0, s} < NumCh);
  assign prevScan = (state_q == SCAN);

  always_comb begin
    state_d = IDLE;
    if (en) begin
      state_d = mode ? SCAN : DIRECT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_d)
        DIRECT: begin
          ptr_q  <= '0;
          cnt_q  <= '0;
          wrap_q <= 1'b0;
          if (sInRange) begin
            y_q     <= chan[s];
            ch_q    <= s;
            valid_q <= 1'b1;
          end else begin
            y_q     <= '0;
            valid_q <= 1'b0;
          end
        end
        SCAN: begin
          y_q     <= chan[ptr_q];
          ch_q    <= ptr_q;
          valid_q <= 1'b1;
          // Gate on prevScan so a leftover direct-mode ch of N-1 cannot fake a wrap.
          wrap_q  <= prevScan && (ch_q == LastCh) && (ptr_q == '0);
          if (cnt_q >= dwell) begin
            cnt_q <= '0;
            ptr_q <= (ptr_q == LastCh) ? '0 : ptr_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          y_q     <= '0;
          valid_q <= 1'b0;
          wrap_q  <= 1'b0;
        end
      endcase
    end
  end

  assign y       = y_q;
  assign ch      = ch_q;
  assign y_valid = valid_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed self-checking bench for mux_scan (N=8, W=1, DW=8): reset, direct
// sweep, enable gating, dwell-0/dwell-2 scans, freeze/resume, mode and dwell switching.
module tb_mux_scan;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic [2:0] s;
  logic [7:0] a;
  logic [7:0] dwell;
  logic [0:0] y;
  logic [2:0] ch;
  logic       yValid;
  logic       wrap;

  int assertCount = 0;
  int failCount   = 0;

  mux_scan #(.N(8), .W(1), .DW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .s       (s),
    .a       (a),
    .dwell   (dwell),
    .y       (y),
    .ch      (ch),
    .y_valid (yValid),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then sample 1 ns later so outputs have settled.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic expY, input logic [2:0] expCh,
                          input logic expValid, input logic expWrap);
    checkOutput({tag, ".y"},     32'(y),      32'(expY));
    checkOutput({tag, ".ch"},    32'(ch),     32'(expCh));
    checkOutput({tag, ".valid"}, 32'(yValid), 32'(expValid));
    checkOutput({tag, ".wrap"},  32'(wrap),   32'(expWrap));
  endtask

  initial begin
    int wrapCount;
    logic [2:0] expCh;

    // Reset held for two edges while enabled in scan mode.
    rst = 1'b1; en = 1'b1; mode = 1'b1; s = 3'd0; a = 8'b10101010; dwell = 8'd0;
    applyStimulus();
    applyStimulus();
    checkAll("reset", 1'b0, 3'd0, 1'b0, 1'b0);

    // Dwell-0 scan: ch = 0..7 each cycle, y = a[ch], wrap only on the return to 0.
    rst = 1'b0;
    wrapCount = 0;
    for (int k = 1; k <= 17; k++) begin
      applyStimulus();
      expCh = 3'((k - 1) % 8);
      checkAll($sformatf("scan0[%0d]", k), expCh[0], expCh, 1'b1, (k > 1) && (expCh == 3'd0));
      if (wrap) wrapCount++;
    end
    checkOutput("scan0.wrapCount", 32'(wrapCount), 32'd2);

    // Direct sweep of all select codes.
    mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      applyStimulus();
      checkAll($sformatf("direct[%0d]", i), i[0], 3'(i), 1'b1, 1'b0);
    end

    // Enable low: outputs idle, ch frozen at 5.
    s = 3'b101;
    applyStimulus();
    checkAll("direct5", 1'b1, 3'd5, 1'b1, 1'b0);
    en = 1'b0;
    applyStimulus();
    checkAll("enLow", 1'b0, 3'd5, 1'b0, 1'b0);

    // Dwell-2 scan from DIRECT: 3 cycles per channel, wrap once at cycle 25.
    en = 1'b1; mode = 1'b0;
    applyStimulus();
    mode = 1'b1; dwell = 8'd2;
    for (int j = 1; j <= 37; j++) begin
      applyStimulus();
      expCh = 3'(((j - 1) / 3) % 8);
      checkAll($sformatf("scan2[%0d]", j), expCh[0], expCh, 1'b1, j == 25);
    end

    // Freeze for 5 cycles in the first dwell cycle of channel 4.
    en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      applyStimulus();
      checkAll($sformatf("freeze[%0d]", j), 1'b0, 3'd4, 1'b0, 1'b0);
    end

    // Resume: two remaining cycles on channel 4, then channel 5.
    en = 1'b1;
    applyStimulus();
    checkAll("resume0", 1'b0, 3'd4, 1'b1, 1'b0);
    a = 8'b01010101;
    applyStimulus();
    checkAll("resumeNewA", 1'b1, 3'd4, 1'b1, 1'b0);
    applyStimulus();
    checkAll("resume5", 1'b0, 3'd5, 1'b1, 1'b0);

    // Mid-scan switch to DIRECT s=6, then back to SCAN restarting at channel 0.
    mode = 1'b0; s = 3'd6;
    applyStimulus();
    checkAll("toDirect6", 1'b1, 3'd6, 1'b1, 1'b0);
    mode = 1'b1;
    applyStimulus();
    checkAll("toScan0", 1'b1, 3'd0, 1'b1, 1'b0);

    // Dwell 10 from a fresh start; drop to 1 once cnt has reached 5.
    mode = 1'b0;
    applyStimulus();
    mode = 1'b1; dwell = 8'd10;
    for (int j = 1; j <= 5; j++) begin
      applyStimulus();
      checkOutput($sformatf("dwell10[%0d].ch", j), 32'(ch), 32'd0);
    end
    dwell = 8'd1;
    applyStimulus();
    checkOutput("dwellDrop.ch0", 32'(ch), 32'd0);
    applyStimulus();
    checkAll("dwellDrop.ch1a", 1'b0, 3'd1, 1'b1, 1'b0);
    applyStimulus();
    checkOutput("dwellDrop.ch1b", 32'(ch), 32'd1);
    applyStimulus();
    checkAll("dwellDrop.ch2", 1'b1, 3'd2, 1'b1, 1'b0);

    // Reset mid-scan, then scanning restarts at channel 0.
    rst = 1'b1;
    applyStimulus();
    checkAll("midReset", 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus();
    checkAll("afterReset", 1'b1, 3'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
